// File: rtl/root_fanin_pkg.sv
// Shared constants, tag-width helper and index type for the root fan-in collector.
package root_fanin_pkg;

   localparam int N_CHILD_DEF = 5;
   localparam int DATA_W_DEF  = 16;
   localparam int CNT_W_DEF   = 8;

   function automatic int src_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   localparam int SRC_W_DEF = src_w(N_CHILD_DEF);

   typedef logic [SRC_W_DEF-1:0] child_idx_t;

endpackage

// File: rtl/root_fanin_collector_if.sv
// Child-side and output-side handshake bundle of the root fan-in collector.
interface root_fanin_collector_if
   import root_fanin_pkg::*;
#(
   parameter int N_CHILD = N_CHILD_DEF,
   parameter int DATA_W  = DATA_W_DEF
);
   localparam int SRC_W = src_w(N_CHILD);

   logic [N_CHILD-1:0]        in_valid;
   logic [N_CHILD-1:0]        in_ready;
   logic [N_CHILD*DATA_W-1:0] in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         out_data;
   logic [SRC_W-1:0]          out_src;

   modport master (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_src
   );

   modport slave (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_src
   );

endinterface

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: searches upward from ptr with wrap.
module rr_arbiter_n
   import root_fanin_pkg::*;
#(
   parameter int N = N_CHILD_DEF
) (
   input  logic [N-1:0]          req,
   input  logic [src_w(N)-1:0]   ptr,
   output logic [N-1:0]          grant,
   output logic [src_w(N)-1:0]   grant_idx
);
   localparam int W = src_w(N);

   logic [W:0]   j;
   logic [W-1:0] idx;
   logic         found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      j         = '0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         j = {1'b0, ptr} + (W+1)'(k);
         if (j >= (W+1)'(N)) j = j - (W+1)'(N);
         idx = j[W-1:0];
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/root_fanin_collector.sv
// Round-robin fan-in of child result beats into one tagged, registered stream.
module root_fanin_collector
   import root_fanin_pkg::*;
#(
   parameter int N_CHILD = N_CHILD_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   root_fanin_collector_if.master   bus,
   output logic [N_CHILD*CNT_W-1:0] beat_cnt,
   output logic                     idle
);
   localparam int SRC_W = src_w(N_CHILD);

   logic [N_CHILD-1:0] grant;
   logic [SRC_W-1:0]   grant_idx;
   logic [SRC_W-1:0]   ptr;
   logic               load_en;
   logic               xfer;
   logic               out_valid_q;
   logic [DATA_W-1:0]  out_data_q;
   logic [SRC_W-1:0]   out_src_q;
   logic [CNT_W-1:0]   cnt [N_CHILD];

   rr_arbiter_n #(.N(N_CHILD)) u_arb (
      .req       (bus.in_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign load_en = !out_valid_q || bus.out_ready;
   // Held low during reset even though load_en is already high then.
   assign bus.in_ready = rst ? '0 : (grant & {N_CHILD{load_en}});
   assign xfer = |bus.in_ready;

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign idle = !out_valid_q && !(|bus.in_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         ptr         <= '0;
      end else if (load_en) begin
         if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data[int'(grant_idx)*DATA_W +: DATA_W];
            out_src_q   <= grant_idx;
            ptr <= (grant_idx == SRC_W'(N_CHILD-1)) ? '0 : grant_idx + 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CHILD; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_CHILD; i++) begin
            if (bus.in_ready[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < N_CHILD; g++) begin : g_cnt
      assign beat_cnt[g*CNT_W +: CNT_W] = cnt[g];
   end

endmodule

// File: tb/tb_root_fanin_collector.sv
// Directed self-checking bench for root_fanin_collector.
module tb_root_fanin_collector;
   import root_fanin_pkg::*;

   localparam int N  = 5;
   localparam int DW = 16;
   localparam int CW = 8;

   logic          clk;
   logic          rst;
   logic [N*CW-1:0] beat_cnt;
   logic          idle;
   int            errors;
   int            checks;

   root_fanin_collector_if #(.N_CHILD(N), .DATA_W(DW)) bus ();

   root_fanin_collector #(.N_CHILD(N), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .beat_cnt (beat_cnt),
      .idle     (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [CW-1:0] cnt_of(input int i);
      return beat_cnt[i*CW +: CW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid  = '1;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 5'b00000) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 00000", bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      checks++;
      if (bus.out_data !== 16'h0) begin
         errors++;
         $display("FAIL reset_out_data: got %h expected 0000", bus.out_data);
      end
      checks++;
      if (bus.out_src !== 3'd0) begin
         errors++;
         $display("FAIL reset_out_src: got %0d expected 0", bus.out_src);
      end
      checks++;
      if (beat_cnt !== '0) begin
         errors++;
         $display("FAIL reset_beat_cnt: got %h expected 0", beat_cnt);
      end
      bus.in_valid = '0;
      #1;
      checks++;
      if (idle !== 1'b1) begin
         errors++;
         $display("FAIL reset_idle: got %b expected 1", idle);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      bus.in_valid = 5'b00100;
      bus.in_data[2*DW +: DW] = 16'hBEEF;
      #1;
      checks++;
      if (bus.in_ready !== 5'b00100) begin
         errors++;
         $display("FAIL single_in_ready: got %b expected 00100", bus.in_ready);
      end
      tick();
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b1, 16'hBEEF, 3'd2}) begin
         errors++;
         $display("FAIL single_out: got v=%b d=%h s=%0d expected v=1 d=beef s=2",
                  bus.out_valid, bus.out_data, bus.out_src);
      end
      checks++;
      if (cnt_of(2) !== 8'd1) begin
         errors++;
         $display("FAIL single_cnt2: got %0d expected 1", cnt_of(2));
      end
      bus.in_valid = '0;
      tick();
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_src, idle} !== {1'b0, 16'hBEEF, 3'd2, 1'b1}) begin
         errors++;
         $display("FAIL single_drain: got v=%b d=%h s=%0d idle=%b expected v=0 d=beef s=2 idle=1",
                  bus.out_valid, bus.out_data, bus.out_src, idle);
      end
   endtask

   task automatic test_round_robin();
      child_idx_t exp_src;
      do_reset();
      for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = 16'h1000 + 16'(i);
      bus.in_valid = '1;
      for (int k = 0; k < 10; k++) begin
         tick();
         exp_src = child_idx_t'(k % 5);
         checks++;
         if ({bus.out_valid, bus.out_src, bus.out_data} !==
             {1'b1, exp_src, 16'h1000 + 16'(k % 5)}) begin
            errors++;
            $display("FAIL rr_beat%0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                     k, bus.out_valid, bus.out_src, bus.out_data,
                     exp_src, 16'h1000 + 16'(k % 5));
         end
      end
      bus.in_valid = '0;
      for (int i = 0; i < N; i++) begin
         checks++;
         if (cnt_of(i) !== 8'd2) begin
            errors++;
            $display("FAIL rr_cnt%0d: got %0d expected 2", i, cnt_of(i));
         end
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = 16'hA000 + 16'(i);
      bus.out_ready = 1'b0;
      bus.in_valid  = 5'b01010;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (bus.in_ready !== 5'b00000) begin
            errors++;
            $display("FAIL bp_in_ready%0d: got %b expected 00000", k, bus.in_ready);
         end
         tick();
         checks++;
         if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b1, 16'h1004, 3'd4}) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b d=%h s=%0d expected v=1 d=1004 s=4",
                     k, bus.out_valid, bus.out_data, bus.out_src);
         end
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 5'b00010) begin
         errors++;
         $display("FAIL bp_release_ready: got %b expected 00010", bus.in_ready);
      end
      tick();
      checks++;
      if ({bus.out_src, bus.out_data} !== {3'd1, 16'hA001}) begin
         errors++;
         $display("FAIL bp_first: got s=%0d d=%h expected s=1 d=a001", bus.out_src, bus.out_data);
      end
      bus.in_valid = 5'b01000;
      tick();
      checks++;
      if ({bus.out_valid, bus.out_src, bus.out_data} !== {1'b1, 3'd3, 16'hA003}) begin
         errors++;
         $display("FAIL bp_second: got v=%b s=%0d d=%h expected v=1 s=3 d=a003",
                  bus.out_valid, bus.out_src, bus.out_data);
      end
      bus.in_valid = '0;
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: got %b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_wrap();
      bus.in_valid = 5'b10000;
      tick();
      checks++;
      if (bus.out_src !== 3'd4) begin
         errors++;
         $display("FAIL wrap_c4: got %0d expected 4", bus.out_src);
      end
      bus.in_valid = 5'b01001;
      #1;
      checks++;
      if (bus.in_ready !== 5'b00001) begin
         errors++;
         $display("FAIL wrap_ready: got %b expected 00001", bus.in_ready);
      end
      tick();
      checks++;
      if ({bus.out_src, bus.out_data} !== {3'd0, 16'hA000}) begin
         errors++;
         $display("FAIL wrap_c0: got s=%0d d=%h expected s=0 d=a000", bus.out_src, bus.out_data);
      end
      bus.in_valid = 5'b01000;
      tick();
      checks++;
      if (bus.out_src !== 3'd3) begin
         errors++;
         $display("FAIL wrap_c3: got %0d expected 3", bus.out_src);
      end
      bus.in_valid = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.in_data[2*DW +: DW] = 16'h2222;
      bus.in_valid = 5'b00100;
      for (int k = 0; k < 7; k++) tick();
      checks++;
      if ({bus.out_valid, cnt_of(2)} !== {1'b1, 8'd7}) begin
         errors++;
         $display("FAIL mid_pre: got v=%b cnt2=%0d expected v=1 cnt2=7", bus.out_valid, cnt_of(2));
      end
      bus.in_valid = '1;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.out_valid, beat_cnt, bus.in_ready} !== {1'b0, 40'h0, 5'b00000}) begin
         errors++;
         $display("FAIL mid_rst: got v=%b cnt=%h rdy=%b expected v=0 cnt=0 rdy=00000",
                  bus.out_valid, beat_cnt, bus.in_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 5'b00001) begin
         errors++;
         $display("FAIL mid_ready: got %b expected 00001", bus.in_ready);
      end
      tick();
      checks++;
      if ({bus.out_valid, bus.out_src} !== {1'b1, 3'd0}) begin
         errors++;
         $display("FAIL mid_first: got v=%b s=%0d expected v=1 s=0", bus.out_valid, bus.out_src);
      end
      bus.in_valid = '0;
   endtask

   task automatic test_saturation();
      do_reset();
      bus.in_valid = 5'b00010;
      for (int k = 0; k < 300; k++) begin
         bus.in_data[1*DW +: DW] = 16'(k);
         tick();
         checks++;
         if ({bus.out_valid, bus.out_src, bus.out_data} !== {1'b1, 3'd1, 16'(k)}) begin
            errors++;
            $display("FAIL sat_beat%0d: got v=%b s=%0d d=%h expected v=1 s=1 d=%h",
                     k, bus.out_valid, bus.out_src, bus.out_data, 16'(k));
         end
      end
      bus.in_valid = '0;
      checks++;
      if (cnt_of(1) !== 8'd255) begin
         errors++;
         $display("FAIL sat_cnt1: got %0d expected 255", cnt_of(1));
      end
      for (int i = 0; i < N; i++) begin
         if (i != 1) begin
            checks++;
            if (cnt_of(i) !== 8'd0) begin
               errors++;
               $display("FAIL sat_cnt%0d: got %0d expected 0", i, cnt_of(i));
            end
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/root_fanin_collector.md
Name: root_fanin_collector

Overview:
- Fan-in counterpart to the root-level fan-out hierarchy: gathers result beats from N_CHILD child instances over independent valid/ready channels.
- Serializes them into one tagged output stream using round-robin arbitration.
- Keeps a saturating per-child beat counter for hierarchy-level observability.
- Sits directly under the root module, one level above the child instances.

Parameters:
- N_CHILD, 5, number of child input channels (2..16).
- DATA_W, 16, payload width per beat.
- CNT_W, 8, width of each per-child saturating beat counter.
- SRC_W, $clog2(N_CHILD), width of the source tag (derived, not overridable).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N_CHILD  per-child beat valid.
- in_ready  output  N_CHILD  per-child beat accept; one-hot or zero.
- in_data  input  N_CHILD*DATA_W  flattened payloads; child i occupies bits [i*DATA_W +: DATA_W].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_W  registered payload.
- out_src  output  SRC_W  index of the child that produced out_data.
- beat_cnt  output  N_CHILD*CNT_W  flattened per-child accepted-beat counts, saturating.
- idle  output  1  high when out_valid=0 and in_valid=0.

Behaviour:
- Reset values (async assert, sync release):
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer=0, all beat_cnt=0.
  - in_ready=0 while rst is high.
- Output stage is a single register.
- load_en = !out_valid | out_ready. Simultaneous drain and refill gives full throughput: one beat per cycle.
- Arbitration:
  - Combinational over in_valid, starting at the pointer and searching upward with wrap from N_CHILD-1 to 0.
  - The first requester wins: grant[i].
  - in_ready = grant & {N_CHILD{load_en}}.
  - in_ready does not depend on in_valid of other channels beyond the arbitration itself.
- Transfer on child i: in_valid[i] & in_ready[i]. Next edge:
  - out_data <= slice i; out_src <= i; out_valid <= 1.
  - Pointer <= (i+1) mod N_CHILD; wrap is explicit for non-power-of-two N_CHILD.
  - beat_cnt[i] <= beat_cnt[i]+1, held at 2^CNT_W-1 once reached.
- Drain with no grant (out_valid & out_ready, no child valid): out_valid <= 0; out_data and out_src hold their last values.
- Stall (out_valid & !out_ready): all in_ready=0; out_data, out_src, out_valid and pointer stable.
- No requesters: pointer holds.
- Latency: input accept to out_valid is 1 cycle.
- Protocol assumptions:
  - A child holds in_valid and in_data stable until accepted.
  - The collector never drops or duplicates a beat.
- Fairness: with all children continuously valid and out_ready=1, grant order is 0,1,2,3,4,0,… with no gaps.
- Reset mid-transfer: a pending out beat is discarded; counters clear; arbitration restarts at child 0.
- idle is combinational from out_valid and in_valid.

Decomposition:
- Package root_fanin_pkg holds:
  - default N_CHILD, DATA_W, CNT_W constants;
  - the SRC_W derivation function;
  - typedef child_idx_t (logic [SRC_W-1:0]).
- One natural sub-module: rr_arbiter_n.
  - Parameter N.
  - Inputs req[N] and ptr; outputs one-hot grant and encoded grant_idx.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset mid-stream: assert rst while out_valid=1 and beat_cnt[2]=7 -> same cycle out_valid=0, beat_cnt all 0, in_ready=0; first grant after release goes to lowest valid child (0).
- Single child: in_valid=5'b00100, in_data[2]=16'hBEEF, out_ready=1 -> next cycle out_valid=1, out_data=16'hBEEF, out_src=2, beat_cnt[2]=1.
- All five valid, out_ready=1 for 10 cycles -> out_src sequence 0,1,2,3,4,0,1,2,3,4; each beat_cnt=2; out_valid continuously 1 from cycle 1.
- Backpressure: out_valid=1, out_ready=0 for 4 cycles with children 1 and 3 valid -> in_ready=0, out_data unchanged; release out_ready -> child granted next follows pointer (1 then 3).
- Pointer wrap: grant child 4, then only child 0 and 3 valid -> child 0 granted first (pointer wrapped to 0), then child 3.
- Saturation (CNT_W=8): 300 beats from child 1 -> beat_cnt[1]=255, other counts 0, every beat still forwarded intact.
